// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with freeze watchdog.
// Define HAZ_PERF_CNT_EN to add saturating load-use/flush/freeze counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_EX,
  input  logic             memRead_EX,
  input  logic             branch_taken_EX,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0] cnt_lu_stall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_freeze,
`endif
  output logic             err_timeout
);

  typedef enum logic [1:0] {RUN, FREEZE, FLUSH} state_t;

  localparam logic [2:0]  FC_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] wd_q, wd_d, wd_inc;
  logic        err_q, err_d;
  logic        lu, fz;
  logic        lu_bubble, redirect_flush;

  assign lu = memRead_EX && (rd_EX != 5'd0) &&
              ((rs1_used_ID && (rs1_ID == rd_EX)) || (rs2_used_ID && (rs2_ID == rd_EX)));
  assign fz = dmem_req && !dmem_ready;
  assign wd_inc = wd_q + 16'd1;
  assign err_timeout = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      wd_q    <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Freeze pauses any state (FLUSH keeps its counter); otherwise RUN and FREEZE act alike.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = fz ? ((wd_q == TO_LIMIT) ? wd_q : wd_inc) : 16'd0;
    err_d   = err_q || (fz && (wd_inc >= TO_LIMIT));
    if (fz) begin
      if (state_q != FLUSH) state_d = FREEZE;
    end else begin
      case (state_q)
        FLUSH: begin
          if (branch_taken_EX) begin
            cnt_d = FC_RELOAD;
          end else if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          if (branch_taken_EX && (FLUSH_CYCLES > 1)) begin
            state_d = FLUSH;
            cnt_d   = FC_RELOAD;
          end
        end
      endcase
    end
  end

  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_stall   = 1'b0;
    lu_bubble      = 1'b0;
    redirect_flush = 1'b0;
    if (!rst) begin
      if (fz) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end else if (state_q == FLUSH) begin
        if_id_flush    = 1'b1;
        id_ex_flush    = branch_taken_EX;
        redirect_flush = 1'b1;
      end else if (branch_taken_EX) begin
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        redirect_flush = 1'b1;
      end else if (lu) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        lu_bubble   = 1'b1;
      end else if (!imem_ready) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  logic [CNT_W-1:0] lu_cnt_q, fl_cnt_q, fz_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
      fz_cnt_q <= '0;
    end else begin
      lu_cnt_q <= sat_inc(lu_cnt_q, lu_bubble);
      fl_cnt_q <= sat_inc(fl_cnt_q, redirect_flush);
      fz_cnt_q <= sat_inc(fz_cnt_q, ex_mem_stall);
    end
  end

  assign cnt_lu_stall = lu_cnt_q;
  assign cnt_flush    = fl_cnt_q;
  assign cnt_freeze   = fz_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives hold/bubble controls of the PC, the IF/ID register, the ID/EX register and the EX/MEM register.
- Resolves four conditions: load-use hazards, taken-branch redirects, instruction-memory wait and data-memory wait.
- Contains a small FSM that holds multi-cycle flushes and freezes, plus a freeze watchdog.

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID stays flushed after a redirect (covers I-mem latency); range 1–7.
- TIMEOUT, 255: maximum consecutive freeze cycles before `err_timeout` sets; range 1–65535.
- CNT_W, 16: width of optional performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- rs1_ID  in  5  source reg 1 of instruction in ID
- rs2_ID  in  5  source reg 2 of instruction in ID
- rs1_used_ID  in  1  instruction in ID reads rs1
- rs2_used_ID  in  1  instruction in ID reads rs2
- rd_EX  in  5  destination reg of instruction in EX
- memRead_EX  in  1  instruction in EX is a load
- branch_taken_EX  in  1  EX resolved a taken branch/jump (PC redirect this cycle)
- imem_ready  in  1  instruction fetch data valid
- dmem_req  in  1  MEM stage has an outstanding access
- dmem_ready  in  1  data memory completes access
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  load NOP/zeros into IF/ID
- id_ex_flush  out  1  load bubble into ID/EX
- ex_mem_stall  out  1  hold EX/MEM and ID/EX
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst=1):
  - state=RUN, flush counter=0, watchdog=0, err_timeout=0.
  - All control outputs are 0 while rst is high.
- Outputs are combinational from current state and inputs; state, counters and error are registered on posedge clk.
- Load-use detect (`lu`) = memRead_EX & rd_EX!=0 & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
- Freeze request (`fz`) = dmem_req & !dmem_ready.
- Priority, highest first: freeze > redirect > load-use > imem wait.
- State RUN:
  - `fz`:
    - Assert pc_stall, if_id_stall, ex_mem_stall; flush outputs 0.
    - Next state FREEZE.
    - Watchdog increments (starting at 1).
  - else branch_taken_EX:
    - Assert if_id_flush and id_ex_flush; pc not stalled (redirect loads).
    - If FLUSH_CYCLES>1, next state FLUSH with counter=FLUSH_CYCLES-1.
  - else `lu`:
    - Assert pc_stall, if_id_stall, id_ex_flush for exactly one cycle.
    - Stays RUN; the hazard clears next cycle because the bubble is now in EX.
  - else !imem_ready: assert pc_stall and if_id_flush (bubble, no stale instruction latched).
  - else all outputs 0.
- State FREEZE:
  - While `fz`: pc_stall, if_id_stall, ex_mem_stall held at 1; watchdog increments.
  - Branch, load-use and imem conditions are ignored (EX contents are held, so they are re-evaluated later).
  - When `fz` deasserts:
    - Outputs evaluate exactly as in RUN in that cycle (a held branch_taken_EX is acted on then).
    - Next state RUN; watchdog clears.
  - Watchdog reaching TIMEOUT sets err_timeout. err_timeout is cleared only by reset; the freeze continues.
- State FLUSH:
  - if_id_flush=1 each cycle; counter decrements; at counter==1→0 return to RUN.
  - `fz` during FLUSH: freeze outputs win and counter pauses; resume FLUSH after the freeze.
  - A new branch_taken_EX during FLUSH reloads counter=FLUSH_CYCLES-1 and asserts id_ex_flush.
  - Load-use is ignored in FLUSH (ID holds a bubble).
- rd_EX==0 never creates a hazard.
- Reset mid-freeze or mid-flush returns immediately to RUN with all outputs 0.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds three outputs, each CNT_W bits, saturating at all-ones and reset to 0:
  - cnt_lu_stall: +1 per load-use bubble cycle.
  - cnt_flush: +1 per cycle with if_id_flush=1 due to redirect or FLUSH state (excludes imem-wait bubbles).
  - cnt_freeze: +1 per cycle with ex_mem_stall=1.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: memRead_EX=1, rd_EX=5, rs1_ID=5, rs1_used_ID=1 for one cycle → pc_stall=if_id_stall=id_ex_flush=1 that cycle only; rd_EX=0 with rs1_ID=0 → no stall.
- Redirect with FLUSH_CYCLES=3: branch_taken_EX pulse → id_ex_flush=1 for 1 cycle, if_id_flush=1 for 3 consecutive cycles, pc_stall=0 throughout.
- Freeze: dmem_req=1, dmem_ready=0 for 4 cycles, with branch_taken_EX=1 held → stalls high 4 cycles, no flush; cycle dmem_ready=1 → if_id_flush=id_ex_flush=1.
- Priority: branch_taken_EX and load-use asserted together → flush outputs only, pc_stall=0.
- Watchdog with TIMEOUT=8: freeze held 10 cycles → err_timeout rises after the 8th freeze cycle and stays high after the freeze ends; drops only on rst.
- Async reset mid-FLUSH: assert rst between clock edges → all outputs 0 immediately; after release with idle inputs, outputs stay 0. With HAZ_PERF_CNT_EN, counters read 0.
